// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with fixed 34-cycle start-to-done latency
module muldiv_unit #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [31:0]       srcA,
  input  logic [31:0]       srcB,
  input  logic [ADDR_W-1:0] rd,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic [ADDR_W-1:0] wrAddr,
  output logic              wrEn
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2, S_DONE = 2'd3;
  logic [1:0] state;
  logic [4:0] cnt;
  logic [2:0] op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [31:0] hi, lo, m, a_mag, b_mag, res;
  logic neg, rneg, sa, sb;
  logic [32:0] sum, shifted, diff;
  logic [63:0] v, n;
  always_comb begin
    sa = srcA[31] & (op[2] ? ~op[0] : (op[0] ^ op[1]));
    sb = srcB[31] & (op[2] ? ~op[0] : (op[1:0] == 2'b01));
    a_mag = sa ? -srcA : srcA;
    b_mag = sb ? -srcB : srcB;
    sum = {1'b0, hi} + {1'b0, m};
    shifted = {hi, lo[31]};
    diff = shifted - {1'b0, m};
    v = op_q[2] ? {32'd0, op_q[1] ? hi : lo} : {hi, lo};
    n = ((op_q[2] & op_q[1]) ? rneg : neg) ? -v : v;
    res = (op_q[2] || op_q[1:0] == 2'b00) ? n[31:0] : n[63:32];
  end
  // hi/lo hold the partial product for multiply, remainder/quotient for divide
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      result <= '0;
      wrAddr <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state <= start ? S_RUN : S_IDLE;
          if (start) begin
            cnt <= '0;
            op_q <= op;
            rd_q <= rd;
            m <= op[2] ? b_mag : a_mag;
            lo <= op[2] ? a_mag : b_mag;
            hi <= '0;
            neg <= (sa ^ sb) & ~(op[2] & (srcB == 32'd0));
            rneg <= op[2] & sa;
          end
        end
        S_RUN: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIN;
          if (op_q[2]) {hi, lo} <= diff[32] ? {shifted[31:0], lo[30:0], 1'b0} : {diff[31:0], lo[30:0], 1'b1};
          else {hi, lo} <= lo[0] ? {sum, lo[31:1]} : {1'b0, hi, lo[31:1]};
        end
        default: begin
          state <= S_DONE;
          result <= res;
          wrAddr <= rd_q;
        end
      endcase
    end
  end
  assign busy = (state == S_RUN) || (state == S_FIN);
  assign done = state == S_DONE;
  assign wrEn = done && (wrAddr != '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven checks of muldiv_unit plus reset and back-to-back sequences
module tb_muldiv_unit;
  logic clk = 0, reset = 1, start = 0;
  logic [2:0] op = 0;
  logic [31:0] srcA = 0, srcB = 0, result;
  logic [5:0] rd = 0, wrAddr;
  logic busy, done, wrEn;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB), .rd(rd),
    .busy(busy), .done(done), .result(result), .wrAddr(wrAddr), .wrEn(wrEn)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // inputs scrambled after acceptance; optional extra start pulse at cycle k+glitch
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [5:0] r, input int glitch, output int lat, output int nb);
    op = o; srcA = a; srcB = b; rd = r; start = 1;
    @(posedge clk); #1;
    start = 0; op = 3'($urandom); srcA = $urandom; srcB = $urandom; rd = 6'($urandom);
    lat = 0; nb = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin lat = c; break; end
      if (busy) nb++;
      if (c == glitch) start = 1;
      @(posedge clk); #1;
      start = 0;
    end
  endtask
  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b;
    logic [5:0] rd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[18];
  int lat, nb;
  initial begin
    vecs[0]  = '{3'b000, 32'd7, 32'd6, 6'd5, 32'h0000002A};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd1, 32'hFFFFFFFE};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2, 32'h00000000};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2, 6'd3, 32'hFFFFFFFF};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2, 6'd4, 32'hFFFFFFFD};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2, 6'd6, 32'hFFFFFFFF};
    vecs[6]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 6'd7, 32'h80000000};
    vecs[7]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 6'd8, 32'h00000000};
    vecs[8]  = '{3'b101, 32'd5, 32'd0, 6'd9, 32'hFFFFFFFF};
    vecs[9]  = '{3'b111, 32'd5, 32'd0, 6'd10, 32'd5};
    vecs[10] = '{3'b100, 32'd5, 32'd0, 6'd11, 32'hFFFFFFFF};
    vecs[11] = '{3'b110, 32'hFFFFFFFB, 32'd0, 6'd12, 32'hFFFFFFFB};
    vecs[12] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd0, 32'h00000001};
    vecs[13] = '{3'b011, 32'h80000000, 32'd4, 6'd63, 32'h00000002};
    vecs[14] = '{3'b001, 32'h80000000, 32'd4, 6'd14, 32'hFFFFFFFE};
    vecs[15] = '{3'b101, 32'd100, 32'd7, 6'd15, 32'd14};
    vecs[16] = '{3'b111, 32'd100, 32'd7, 6'd16, 32'd2};
    vecs[17] = '{3'b100, 32'd7, 32'hFFFFFFFE, 6'd17, 32'hFFFFFFFD};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wren", 32'(wrEn), 0);
    chk("rst_result", result, 0);
    chk("rst_wraddr", 32'(wrAddr), 0);
    reset = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, (i == 0) ? 5 : 0, lat, nb);
      chk($sformatf("v%0d_result", i), result, vecs[i].exp);
      chk($sformatf("v%0d_wraddr", i), 32'(wrAddr), 32'(vecs[i].rd));
      chk($sformatf("v%0d_wren", i), 32'(wrEn), 32'(vecs[i].rd != 0));
      chk($sformatf("v%0d_latency", i), lat, 34);
      chk($sformatf("v%0d_busy_cycles", i), nb, 33);
      chk($sformatf("v%0d_busy_in_done", i), 32'(busy), 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_low", i), 32'(done), 0);
      chk($sformatf("v%0d_wren_low", i), 32'(wrEn), 0);
      chk($sformatf("v%0d_result_held", i), result, vecs[i].exp);
    end
    run(3'b000, 32'd3, 32'd3, 6'd0, 0, lat, nb);
    chk("b2b1_latency", lat, 34);
    chk("b2b1_result", result, 32'd9);
    chk("b2b1_wren", 32'(wrEn), 0);
    run(3'b000, 32'h10, 32'h10, 6'd9, 0, lat, nb);
    chk("b2b2_latency", lat, 34);
    chk("b2b2_busy_cycles", nb, 33);
    chk("b2b2_result", result, 32'h100);
    chk("b2b2_wren", 32'(wrEn), 1);
    @(posedge clk); #1;
    op = 3'b100; srcA = 32'd100; srcB = 32'd7; rd = 6'd3; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_busy", 32'(busy), 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_wren", 32'(wrEn), 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_wraddr", 32'(wrAddr), 0);
    nb = 0;
    repeat (40) begin
      if (done || wrEn || busy) nb++;
      @(posedge clk); #1;
    end
    chk("post_rst_activity", nb, 0);
    op = 3'b000; srcA = 32'd2; srcB = 32'd2; rd = 6'd4; start = 1; reset = 1;
    @(posedge clk); #1;
    start = 0; reset = 0;
    chk("rst_over_start_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("rst_over_start_busy2", 32'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, destination register address width (matches regfile addr3).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port srcA  input  32  rs1 operand (regfile readData1).
REQ-007 SHALL have port srcB  input  32  rs2 operand (regfile readData2).
REQ-008 SHALL have port rd  input  ADDR_W  destination register.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port result  output  32  writeback data (to regfile writeData3).
REQ-012 SHALL have port wrAddr  output  ADDR_W  writeback address (to regfile addr3).
REQ-013 SHALL have port wrEn  output  1  writeback enable (to regfile we3).

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> FIN -> DONE -> IDLE.
REQ-015 SHALL, in IDLE with start=1 at edge k, latch op, srcA, srcB, rd, clear the 5-bit iteration counter, enter RUN.
REQ-016 SHALL ignore start in RUN, FIN; operands held internally, input changes after acceptance have no effect.
REQ-017 SHALL perform one radix-2 iteration per RUN cycle: shift-add multiply (64-bit product) or restoring divide (32-bit quotient/remainder), on operand magnitudes.
REQ-018 SHALL leave RUN after exactly 32 iterations (counter 31 -> FIN); FIN applies sign correction, selects the output word, registers result.
REQ-019 SHALL make fixed latency: busy=1 in cycles k+1..k+33, done=1 only in cycle k+34 (DONE), busy=0 in DONE.
REQ-020 SHALL select MUL low 32 bits; MULH high 32 signed x signed; MULHSU high 32 signed srcA x unsigned srcB; MULHU high 32 unsigned x unsigned.
REQ-021 SHALL round DIV/REM toward zero; remainder sign equals dividend sign.
REQ-022 SHALL, on divide by zero, give DIV/DIVU = 0xFFFFFFFF, REM/REMU = srcA; same latency.
REQ-023 SHALL, on DIV overflow (0x80000000 / 0xFFFFFFFF), give quotient 0x80000000, REM 0; same latency.
REQ-024 SHALL drive wrEn = done AND (wrAddr != 0); x0 never written.
REQ-025 SHALL hold result and wrAddr stable from DONE until next FIN; wrEn=0 outside DONE.
REQ-026 SHALL accept start during DONE (back-to-back): next op result in DONE at +34 cycles, no idle cycle required.

Reset
REQ-027 SHALL, with reset=1 at any edge (including mid-RUN/FIN/DONE), go to IDLE with busy=0, done=0, wrEn=0, result=0, wrAddr=0, counter=0; in-flight op discarded, no writeback.
REQ-028 SHALL give reset priority over start in the same cycle.
REQ-029 SHALL not need any output driven before the first reset; all outputs 0 from the cycle after reset.

Verification
REQ-030 SHALL check MUL srcA=7, srcB=6, rd=5 -> done at k+34, result=0x0000002A, wrAddr=5, wrEn=1; busy high exactly 33 cycles.
REQ-031 SHALL check MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-032 SHALL check DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-033 SHALL check DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, latency unchanged.
REQ-034 SHALL check reset at k+10 of DIV -> busy=0 next cycle, no done or wrEn in following 40 cycles; start ignored at k+5.
REQ-035 SHALL check MUL 3x3 rd=0 -> done=1, result=9, wrEn=0; then start asserted in DONE -> second result at +34.
